// File: rtl/seg7_estado_decodificador.sv
// Recovers the 5-bit FSM state code shown on an active-low 7-segment bus.
// It filters glitches, then queues each accepted code in a FIFO. Build option: SEG7_ESTADO_DEDUP_EN.
module seg7_estado_decodificador #(
    parameter int ESTAVEL      = 4,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [6:0]                        display,
    input  logic                              ler,
    output logic [4:0]                        estado,
    output logic                              valido,
    output logic [$clog2(PROFUNDIDADE+1)-1:0] contagem,
    output logic                              erro_padrao,
    output logic                              erro_overflow
);
    localparam int         PW     = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int         CW     = $clog2(PROFUNDIDADE+1);
    localparam logic [3:0] EST    = 4'(ESTAVEL);
    localparam logic [3:0] EST_M1 = 4'(ESTAVEL - 1);
    localparam logic [6:0] BLANK  = 7'h7F;

    logic [6:0]                         amostra_q, amostra_d;
    logic [3:0]                         cont_q, cont_d;
    logic [6:0]                         ultimo_q, ultimo_d;
    logic [PROFUNDIDADE-1:0][4:0]       mem_q;
    logic [PW-1:0]                      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               perr_q, ovf_q;

    logic       same, aceita, dec_ok, dup, push_req, push, pop, full, drop, pad_err;
    logic [4:0] dec_code;

    always_comb begin
        dec_ok   = 1'b1;
        dec_code = 5'd0;
        case (display)
            7'h40: dec_code = 5'h00;  7'h79: dec_code = 5'h01;
            7'h24: dec_code = 5'h02;  7'h30: dec_code = 5'h03;
            7'h19: dec_code = 5'h04;  7'h12: dec_code = 5'h05;
            7'h02: dec_code = 5'h06;  7'h78: dec_code = 5'h07;
            7'h00: dec_code = 5'h08;  7'h10: dec_code = 5'h09;
            7'h08: dec_code = 5'h0A;  7'h03: dec_code = 5'h0B;
            7'h46: dec_code = 5'h0C;  7'h21: dec_code = 5'h0D;
            7'h06: dec_code = 5'h0E;  7'h0E: dec_code = 5'h0F;
            7'h7E: dec_code = 5'h10;  7'h7D: dec_code = 5'h11;
            7'h7B: dec_code = 5'h12;  7'h77: dec_code = 5'h13;
            7'h6F: dec_code = 5'h14;  7'h5F: dec_code = 5'h15;
            7'h3F: dec_code = 5'h16;  7'h7C: dec_code = 5'h17;
            7'h73: dec_code = 5'h18;  7'h67: dec_code = 5'h19;
            7'h4F: dec_code = 5'h1A;  7'h1F: dec_code = 5'h1B;
            7'h71: dec_code = 5'h1C;  7'h63: dec_code = 5'h1D;
            7'h47: dec_code = 5'h1E;  7'h0F: dec_code = 5'h1F;
            default: dec_ok = 1'b0;
        endcase
    end

    // Acceptance fires only on the cont ESTAVEL-1 -> ESTAVEL step, so once per episode.
    assign same   = (display == amostra_q);
    assign aceita = same && (cont_q == EST_M1);

    always_comb begin
        amostra_d = display;
        cont_d    = 4'd1;
        if (same)
            cont_d = (cont_q == EST) ? cont_q : cont_q + 4'd1;
        ultimo_d  = aceita ? display : ultimo_q;
    end

`ifdef SEG7_ESTADO_DEDUP_EN
    // Decode map is injective, so pattern equality is code equality.
    assign dup = (display == ultimo_q);
`else
    assign dup = 1'b0;
`endif

    assign valido   = (cnt_q != '0);
    assign estado   = valido ? mem_q[rd_ptr_q] : 5'd0;
    assign contagem = cnt_q;

    assign full     = (cnt_q == CW'(PROFUNDIDADE));
    assign pop      = ler && valido;
    assign push_req = aceita && dec_ok && !dup;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign pad_err  = aceita && !dec_ok && (display != BLANK);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            amostra_q <= BLANK;
            cont_q    <= 4'd0;
            ultimo_q  <= BLANK;
            mem_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            amostra_q <= amostra_d;
            cont_q    <= cont_d;
            ultimo_q  <= ultimo_d;
            cnt_q     <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dec_code;
                wr_ptr_q        <= PW'(wr_ptr_q + 1'b1);
            end
            if (pop)
                rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
            if (pad_err)
                perr_q <= 1'b1;
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    assign erro_padrao   = perr_q;
    assign erro_overflow = ovf_q;
endmodule

// File: tb/tb_seg7_estado_decodificador.sv
// Self-checking bench: directed scenarios plus random traffic.
// Outputs are compared every cycle against a queue-based reference model.
module tb_seg7_estado_decodificador;
    localparam int ESTAVEL = 4;
    localparam int PROF    = 4;
    localparam int CW      = $clog2(PROF+1);

    logic          clock = 1'b0;
    logic          reset;
    logic [6:0]    display;
    logic          ler;
    logic [4:0]    estado;
    logic          valido;
    logic [CW-1:0] contagem;
    logic          erro_padrao, erro_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_estado_decodificador #(.ESTAVEL(ESTAVEL), .PROFUNDIDADE(PROF)) dut (
        .clock(clock), .reset(reset), .display(display), .ler(ler),
        .estado(estado), .valido(valido), .contagem(contagem),
        .erro_padrao(erro_padrao), .erro_overflow(erro_overflow)
    );

    always #5 clock = ~clock;

    // Index in this table is the state code.
    logic [6:0] tabela [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F, 7'h7C,
        7'h73, 7'h67, 7'h4F, 7'h1F, 7'h71, 7'h63, 7'h47, 7'h0F };

    // Reference model: display history since reset plus a queue of codes.
    logic [6:0] hist [$];
    logic [4:0] mq   [$];
    logic [6:0] m_last;
    bit         m_perr, m_ovf, started = 0;
    logic [4:0] m_estado;
    int         m_cnt;

    always @(posedge clock) begin
        bit acc, found, dupl, popped;
        int code;
        if (reset) begin
            hist.delete(); mq.delete();
            m_perr = 0; m_ovf = 0; m_last = 7'h7F; started = 1;
        end else begin
            popped = ler && (mq.size() > 0);
            hist.push_back(display);
            if (hist.size() > ESTAVEL + 1) void'(hist.pop_front());
            // Accept when the last ESTAVEL samples match and the one before them did not.
            acc = 0;
            if (hist.size() >= ESTAVEL) begin
                acc = 1;
                for (int k = 0; k < ESTAVEL; k++)
                    if (hist[hist.size()-1-k] != display) acc = 0;
                if (hist.size() == ESTAVEL + 1 && hist[0] == display) acc = 0;
            end
            if (popped) void'(mq.pop_front());
            if (acc) begin
                found = 0; code = 0;
                for (int c = 0; c < 32; c++)
                    if (tabela[c] == display) begin found = 1; code = c; end
                if (display != 7'h7F) begin
                    if (!found) m_perr = 1;
                    else begin
`ifdef SEG7_ESTADO_DEDUP_EN
                        dupl = (display == m_last);
`else
                        dupl = 0;
`endif
                        if (!dupl) begin
                            if (mq.size() < PROF) mq.push_back(5'(code));
                            else m_ovf = 1;
                        end
                    end
                end
                m_last = display;
            end
        end
        m_cnt    = mq.size();
        m_estado = (mq.size() > 0) ? mq[0] : 5'd0;
    end

    always @(negedge clock) begin
        if (started) begin
            n_cmp++;
            if (estado !== m_estado || valido !== (m_cnt > 0) || contagem !== CW'(m_cnt) ||
                erro_padrao !== m_perr || erro_overflow !== m_ovf) begin
                n_bad++;
                $display("FAIL model t=%0t estado=%h/%h valido=%b/%b contagem=%0d/%0d perr=%b/%b ovf=%b/%b (actual/required)",
                         $time, estado, m_estado, valido, m_cnt > 0, contagem, m_cnt,
                         erro_padrao, m_perr, erro_overflow, m_ovf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n, input bit rl);
        display = p;
        repeat (n) begin
            if (rl) ler = ($urandom_range(0, 3) == 0);
            @(negedge clock);
        end
        if (rl) ler = 1'b0;
    endtask

    task automatic pop1();
        ler = 1'b1;
        @(negedge clock);
        ler = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (valido && guard < 2 * PROF) begin pop1(); guard++; end
        chk("drain_empty", valido, 0);
    endtask

    initial begin
        int exp_n;
        reset = 1'b1; display = 7'h7F; ler = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_valido", valido, 0);
        chk("reset_contagem", contagem, 0);
        chk("reset_flags", {erro_padrao, erro_overflow}, 0);
        reset = 1'b0;
        hold(7'h7F, 6, 0);

        // 24 -> code 02 after exactly four edges
        hold(7'h24, 3, 0);
        chk("t1_not_yet", valido, 0);
        hold(7'h24, 1, 0);
        chk("t1_valido", valido, 1);
        chk("t1_estado", estado, 2);
        chk("t1_contagem", contagem, 1);
        chk("t1_model", m_estado, 2);
        pop1();

        // short 0F then blank: nothing queued
        hold(7'h0F, 3, 0);
        hold(7'h7F, 6, 0);
        chk("t2_contagem", contagem, 0);
        chk("t2_flags", {erro_padrao, erro_overflow}, 0);

        // overflow and in-order drain
        hold(7'h40, 6, 0); hold(7'h79, 6, 0); hold(7'h24, 6, 0);
        hold(7'h30, 6, 0); hold(7'h19, 6, 0);
        chk("t3_ovf", erro_overflow, 1);
        chk("t3_contagem", contagem, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", estado, i);
            pop1();
        end
        chk("t3_empty", valido, 0);

        // invalid pattern sets sticky erro_padrao
        hold(7'h55, 5, 0);
        chk("t4_perr", erro_padrao, 1);
        chk("t4_contagem", contagem, 0);
        hold(7'h7F, 8, 0);
        chk("t4_sticky", erro_padrao, 1);

        // 47, one-edge blank glitch, 47
        hold(7'h47, 6, 0); hold(7'h7F, 1, 0); hold(7'h47, 6, 0);
`ifdef SEG7_ESTADO_DEDUP_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        chk("t5_count", contagem, exp_n);
        chk("t5_head", estado, 5'h1E);
        drain();

        // full FIFO with pop on the accepting edge
        hold(7'h40, 6, 0); hold(7'h79, 6, 0); hold(7'h24, 6, 0); hold(7'h30, 6, 0);
        hold(7'h0F, 3, 0);
        ler = 1'b1;
        @(negedge clock);
        ler = 1'b0;
        chk("t6_contagem", contagem, 4);
        pop1(); pop1(); pop1();
        chk("t6_last", estado, 5'h1F);
        pop1();
        chk("t6_empty", valido, 0);

        // random traffic with occasional resets
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [6:0] p;
            r = $urandom_range(0, 9);
            if (r <= 5)      p = tabela[$urandom_range(0, 31)];
            else if (r == 6) p = 7'h7F;
            else if (r == 7) p = 7'($urandom_range(0, 127));
            else             p = display;
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            hold(p, $urandom_range(1, 7), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_estado_decodificador.md
# seg7_estado_decodificador

Inverse of the 5-bit state-to-seven-segment display mapping: watches an active-low 7-segment pattern bus, filters glitches, recovers the 5-bit FSM state code, and queues each newly displayed code in a small FIFO. It sits in the verification and debug path of the memory-game project. It lets a bench or a second board observe the state sequence shown on a HEX display without access to the FSM itself.

## Interface
Parameters:
- ESTAVEL, default 4: consecutive rising edges a pattern must be present before acceptance (legal range 2..15).
- PROFUNDIDADE, default 4: FIFO depth in entries (power of two, 2..16).

Ports:
- clock, input, 1: single system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- display, input, 7: active-low segment pattern; bit 6 is segment g, bit 0 is segment a.
- ler, input, 1: pop request; acts only when valido=1.
- estado, output, 5: code at the FIFO head; 0 when empty.
- valido, output, 1: FIFO not empty.
- contagem, output, $clog2(PROFUNDIDADE+1): FIFO occupancy.
- erro_padrao, output, 1: sticky; an accepted pattern matched no code.
- erro_overflow, output, 1: sticky; a code was dropped because the FIFO was full.

## Operation
- The decode table maps display pattern (hex) to code.
  - Codes 00–0F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
  - Codes 10–1F: 7E 7D 7B 77 6F 5F 3F 7C 73 67 4F 1F 71 63 47 0F.
- Pattern 7F (blank) is legal, never queued, and never flags an error.
- Any other pattern is invalid.
- Stability filter:
  - Register `amostra` holds the previous edge's display value. Counter `cont` saturates at ESTAVEL.
  - On each edge: if display ≠ amostra, then amostra←display and cont←1. Otherwise cont increments.
  - Acceptance fires on the edge where cont goes ESTAVEL−1→ESTAVEL. It fires once per stable episode.
- On acceptance of pattern P:
  - `ultimo` ← P.
  - P=7F: no further action.
  - P invalid: set erro_padrao.
  - P valid: write its code to the FIFO, subject to the dedup rule in Configuration.
- FIFO:
  - Circular buffer with read/write pointers.
  - estado and valido reflect the head combinationally from registers.
  - Pop occurs when ler=1 and valido=1 at the edge. ler while empty is ignored.
- Boundary conditions:
  - Write when full and no pop: the code is dropped and erro_overflow is set.
  - Write and pop on the same edge when full: both succeed; contagem stays at PROFUNDIDADE.
  - Write and pop on the same edge when contagem=1: the new code becomes the head; valido stays 1.
  - Pointers wrap modulo PROFUNDIDADE.
- Sticky flags clear only on reset.

## Timing
- Reset values: FIFO empty, estado=0, valido=0, contagem=0, erro_padrao=0, erro_overflow=0, amostra=7F, cont=0, ultimo=7F.
- Latency: pattern P is present at edges E1..E(ESTAVEL), where E1 is the first edge at which it differs from amostra.
  - For ESTAVEL=4: first edge loads amostra and cont=1; edges 2 and 3 raise cont to 2 and 3; edge 4 takes cont 3→4 and fires acceptance.
  - The FIFO write commits at E(ESTAVEL); valido/estado update immediately after that edge.
  - Total latency is ESTAVEL edges from E1.
- A pattern held for ESTAVEL−1 edges or fewer is discarded and does not alter `ultimo`.
- Reset asserted mid-episode: everything returns to reset values at that edge. A pattern held through reset release restarts counting at the first edge after release.
- Pop takes effect at the edge; the next entry is visible after that edge.

## Configuration
- Macro `SEG7_ESTADO_DEDUP_EN`.
- Defined: a valid accepted pattern equal to `ultimo` (prior value) is not queued. For example, a glitch A→X(1 edge)→A yields a single A entry.
- Undefined: every accepted valid pattern is queued, even if equal to the previous accepted pattern, so A→X(1 edge)→A yields two A entries.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then hold 24 (code 02) for 4 edges → valido=1, estado=02, contagem=1 after edge 4; no change at edges 1–3.
- Apply 0F held for 3 edges, then 7F → nothing queued, no error flags.
- Apply the sequence 40,79,24,30,19 (each held 6 edges) with ler=0 → 4 entries 00..03, then erro_overflow=1 with contagem=4. Pop all → 00,01,02,03 in order, then valido=0.
- Apply 55 held for 5 edges → erro_padrao=1, contagem unchanged; flag stays set until reset.
- Apply 47 held, 7F for 1 edge, then 47 held; with the macro defined → one 1E entry; without the macro → two 1E entries.
- With FIFO full, pulse ler on the accepting edge of 0F → contagem stays 4; the last entry after draining is 1F.
